// File: rtl/axi_ic_defs_pkg.sv
// rtl/axi_ic_defs_pkg.sv - shared AXI interconnect constants and read FSM state codes
package axi_ic_defs_pkg;
  localparam int NUM_MST    = 4;
  localparam int DDR_ADDR_W = 28;
  localparam int DDR_LEN_W  = 4;
  localparam int DDR_ID_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;
endpackage

// File: rtl/axi_rr_arb4.sv
// rtl/axi_rr_arb4.sv - 4-request arbiter, first requester at or above ptr wins
module axi_rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);
  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the closest requester above ptr is kept last.
  always_comb begin
    gnt_idx   = 2'd0;
    gnt_valid = 1'b0;
    cand      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
    gnt = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
  end
endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - 4-master single-outstanding DDR read arbiter with protocol checks
// AXI_RD_FIXED_PRIO_EN: fixed priority (master 0 highest) instead of round-robin.
module axi_rd_arbiter
  import axi_ic_defs_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_MST*ID_WIDTH-1:0]   s_arid,
  input  logic [NUM_MST*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_MST*8-1:0]          s_arlen,
  input  logic [NUM_MST-1:0]            s_arvalid,
  output logic [NUM_MST-1:0]            s_arready,
  output logic [NUM_MST*DATA_WIDTH-1:0] s_rdata,
  output logic [NUM_MST-1:0]            s_rvalid,
  output logic [NUM_MST-1:0]            s_rlast,
  output logic [DDR_ADDR_W-1:0]         axi_araddr,
  output logic [DDR_ID_W-1:0]           axi_aruser_id,
  output logic [DDR_LEN_W-1:0]          axi_arlen,
  output logic                          axi_arvalid,
  input  logic                          axi_arready,
  input  logic [DATA_WIDTH-1:0]         axi_rdata,
  input  logic [DDR_ID_W-1:0]           axi_rid,
  input  logic                          axi_rlast,
  input  logic                          axi_rvalid,
  output logic                          rd_err
);
  state_t                 state, state_nxt;
  logic [1:0]             grant_idx, rr_ptr;
  logic [DDR_LEN_W-1:0]   beat_cnt, len4;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [7:0]             sel_len;
  logic [3:0]             arb_gnt;
  logic [1:0]             arb_idx;
  logic                   arb_valid;
  logic                   ar_hs, r_beat;
  logic                   unused_ok;

  axi_rr_arb4 u_arb (
    .req       (s_arvalid),
    .ptr       (rr_ptr),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  assign sel_addr      = s_araddr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_len       = s_arlen[int'(grant_idx)*8 +: 8];
  assign axi_araddr    = sel_addr[DDR_ADDR_W-1:0];
  assign axi_arlen     = sel_len[DDR_LEN_W-1:0];
  assign axi_aruser_id = {2'b00, grant_idx};
  assign s_rdata       = {NUM_MST{axi_rdata}};
  assign ar_hs         = (state == ADDR) && axi_arready;
  assign r_beat        = (state == DATA) && axi_rvalid;
  // IDs are accepted for protocol completeness only; the controller sees the grant index.
  assign unused_ok     = ^{s_arid, sel_addr, arb_gnt};

  always_comb begin
    state_nxt   = state;
    axi_arvalid = 1'b0;
    s_arready   = '0;
    s_rvalid    = '0;
    s_rlast     = '0;
    case (state)
      IDLE: if (arb_valid) state_nxt = ADDR;
      ADDR: begin
        axi_arvalid          = 1'b1;
        s_arready[grant_idx] = axi_arready;
        if (axi_arready) state_nxt = DATA;
      end
      DATA: begin
        s_rvalid[grant_idx] = axi_rvalid;
        s_rlast[grant_idx]  = axi_rlast;
        if (axi_rvalid && axi_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      grant_idx <= 2'd0;
      rr_ptr    <= 2'd0;
      beat_cnt  <= '0;
      len4      <= '0;
      rd_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && arb_valid) grant_idx <= arb_idx;
      if (ar_hs) begin
        len4     <= sel_len[DDR_LEN_W-1:0];
        beat_cnt <= '0;
        if (sel_len[7:4] != 4'd0) rd_err <= 1'b1;
      end
      if (r_beat) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (axi_rid != {2'b00, grant_idx}) rd_err <= 1'b1;
        // The final beat must be exactly the one at index len4, and vice versa.
        if (axi_rlast != (beat_cnt == len4)) rd_err <= 1'b1;
        if (axi_rlast) begin
`ifdef AXI_RD_FIXED_PRIO_EN
          rr_ptr <= 2'd0;
`else
          rr_ptr <= grant_idx + 2'd1;
`endif
        end
      end
      if (axi_rvalid && state != DATA) rd_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [15:0]   s_arid;
  logic [127:0]  s_araddr;
  logic [31:0]   s_arlen;
  logic [3:0]    s_arvalid;
  logic [3:0]    s_arready;
  logic [1023:0] s_rdata;
  logic [3:0]    s_rvalid;
  logic [3:0]    s_rlast;
  logic [27:0]   axi_araddr;
  logic [3:0]    axi_aruser_id;
  logic [3:0]    axi_arlen;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [255:0]  axi_rdata;
  logic [3:0]    axi_rid;
  logic          axi_rlast;
  logic          axi_rvalid;
  logic          rd_err;

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  axi_rd_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
    .axi_araddr(axi_araddr), .axi_aruser_id(axi_aruser_id), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .rd_err(rd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET      = 1'b1;
    s_arid      = '0;
    s_araddr    = '0;
    s_arlen     = '0;
    s_arvalid   = '0;
    axi_arready = 1'b0;
    axi_rdata   = '0;
    axi_rid     = '0;
    axi_rlast   = 1'b0;
    axi_rvalid  = 1'b0;
    tick();
    ARESET = 1'b0;
  endtask

  task automatic request(input int m, input logic [31:0] addr, input logic [7:0] len);
    s_araddr[m*32 +: 32] = addr;
    s_arlen[m*8 +: 8]    = len;
    s_arid[m*4 +: 4]     = 4'(m + 5);
    s_arvalid[m]         = 1'b1;
  endtask

  task automatic wait_ar(input string tag);
    int n = 0;
    while (!axi_arvalid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(axi_arvalid), 32'd1);
  endtask

  // One R beat from the controller; checks routing mask combinationally, then clocks it in.
  task automatic beat(input string tag, input logic [3:0] rid, input logic last, input logic [3:0] mask);
    axi_rvalid = 1'b1;
    axi_rid    = rid;
    axi_rlast  = last;
    axi_rdata  = {8{32'hC0DE_0000 | 32'(rid)}};
    #1;
    chk({tag, "_rvalid"}, 32'(s_rvalid), 32'(mask));
    chk({tag, "_rlast"}, 32'(s_rlast), last ? 32'(mask) : 32'd0);
    tick();
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
  endtask

  initial begin
    int exp_g;
    logic [3:0] g;

    // Reset state
    do_reset();
    chk("rst_arvalid", 32'(axi_arvalid), 0);
    chk("rst_arready", 32'(s_arready), 0);
    chk("rst_rvalid", 32'(s_rvalid), 0);
    chk("rst_rlast", 32'(s_rlast), 0);
    chk("rst_err", 32'(rd_err), 0);

    // Single burst from master 1, 4 beats
    axi_arready = 1'b1;
    request(1, 32'h0000_1000, 8'd3);
    tick();
    chk("s1_arvalid", 32'(axi_arvalid), 1);
    chk("s1_araddr", 32'(axi_araddr), 32'h0001000);
    chk("s1_userid", 32'(axi_aruser_id), 1);
    chk("s1_arlen", 32'(axi_arlen), 3);
    chk("s1_arready", 32'(s_arready), 32'h2);
    tick();
    s_arvalid = '0;
    chk("s1_arvalid_off", 32'(axi_arvalid), 0);
    for (int k = 0; k < 4; k++) beat("s1_beat", 4'd1, k == 3, 4'b0010);
    chk("s1_rdata", s_rdata[256 +: 32], 32'hC0DE_0001);
    chk("s1_err", 32'(rd_err), 0);

    // All four masters requesting, one-beat bursts back to back
    do_reset();
    axi_arready = 1'b1;
    for (int m = 0; m < 4; m++) request(m, 32'(m) << 12, 8'd0);
    for (int i = 0; i < 5; i++) begin
`ifdef AXI_RD_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % 4;
`endif
      wait_ar("rr_wait");
      g = axi_aruser_id;
      chk("rr_grant", 32'(g), 32'(exp_g));
      tick();
      beat("rr_beat", g, 1'b1, 4'b0001 << g[1:0]);
    end
    chk("rr_err", 32'(rd_err), 0);

    // AR stall: arready low for 5 cycles in ADDR
    do_reset();
    request(3, 32'hABCD_1234, 8'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_arvalid", 32'(axi_arvalid), 1);
      chk("stall_addr", 32'(axi_araddr), 32'hBCD_1234);
      chk("stall_arready", 32'(s_arready), 0);
      tick();
    end
    axi_arready = 1'b1;
    #1;
    chk("stall_hs", 32'(s_arready), 32'h8);
    tick();
    axi_arready = 1'b0;
    s_arvalid   = '0;
    #1;
    chk("stall_hs_once", 32'(s_arready), 0);
    beat("stall_beat", 4'd3, 1'b1, 4'b1000);
    chk("stall_err", 32'(rd_err), 0);

    // Wrong RID: beats still routed to master 2, sticky error
    do_reset();
    axi_arready = 1'b1;
    request(2, 32'h0000_2000, 8'd1);
    wait_ar("rid_wait");
    tick();
    s_arvalid = '0;
    beat("rid_b0", 4'd1, 1'b0, 4'b0100);
    chk("rid_err", 32'(rd_err), 1);
    beat("rid_b1", 4'd1, 1'b1, 4'b0100);
    tick();
    tick();
    chk("rid_err_sticky", 32'(rd_err), 1);

    // arlen upper nibble nonzero
    do_reset();
    axi_arready = 1'b1;
    request(0, 32'h0000_3000, 8'h13);
    wait_ar("len_wait");
    chk("len_arlen", 32'(axi_arlen), 3);
    chk("len_err_pre", 32'(rd_err), 0);
    tick();
    s_arvalid = '0;
    chk("len_err", 32'(rd_err), 1);
    for (int k = 0; k < 4; k++) beat("len_beat", 4'd0, k == 3, 4'b0001);

    // Early rlast: len 3, rlast on beat 2
    do_reset();
    axi_arready = 1'b1;
    request(0, 32'h0000_4000, 8'd3);
    wait_ar("early_wait");
    tick();
    s_arvalid = '0;
    beat("early_b0", 4'd0, 1'b0, 4'b0001);
    chk("early_err_pre", 32'(rd_err), 0);
    beat("early_b1", 4'd0, 1'b1, 4'b0001);
    chk("early_err", 32'(rd_err), 1);
    request(1, 32'h0000_5000, 8'd0);
    tick();
    chk("early_idle_regrant", 32'(axi_arvalid), 1);
    chk("early_idle_user", 32'(axi_aruser_id), 1);
    s_arvalid = '0;

    // Reset during DATA after 2 of 8 beats; stray beats set the error
    do_reset();
    axi_arready = 1'b1;
    request(1, 32'h0000_6000, 8'd7);
    wait_ar("abort_wait");
    tick();
    s_arvalid = '0;
    beat("abort_b0", 4'd1, 1'b0, 4'b0010);
    beat("abort_b1", 4'd1, 1'b0, 4'b0010);
    axi_rvalid = 1'b1;
    axi_rid    = 4'd1;
    ARESET     = 1'b1;
    #1;
    chk("abort_rvalid", 32'(s_rvalid), 0);
    chk("abort_arvalid", 32'(axi_arvalid), 0);
    chk("abort_err_rst", 32'(rd_err), 0);
    #1;
    ARESET = 1'b0;
    tick();
    chk("abort_stray_drop", 32'(s_rvalid), 0);
    chk("abort_stray_err", 32'(rd_err), 1);
    axi_rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
